// File: rtl/instr_fetch_seq.sv
// Instruction-fetch sequencer: holds the PC and a loadable instruction memory,
// issues one instruction word per execute window and resolves j/beq targets.
module instr_fetch_seq #(
   parameter int unsigned IMEM_DEPTH       = 64,
   parameter int unsigned ADDR_W           = 6,
   parameter int unsigned CYCLES_PER_INSTR = 3,
   parameter logic [31:0] HALT_WORD        = 32'hFFFFFFFF,
   parameter logic [31:0] RESET_PC         = 32'h00000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   input  logic              br_equal,
   output logic [31:0]       instrword,
   output logic              newinstr,
   output logic [31:0]       pc,
   output logic              busy,
   output logic              halted,
   output logic              pc_fault,
   output logic [15:0]       instr_count
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   // Counter only needs to reach CYCLES_PER_INSTR-1.
   localparam int unsigned CNT_W = (CYCLES_PER_INSTR > 1) ? $clog2(CYCLES_PER_INSTR) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_INSTR - 1);
   localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);

   localparam logic [5:0] OP_J   = 6'd2;
   localparam logic [5:0] OP_BEQ = 6'd4;

   logic [31:0]      imem_q [IMEM_DEPTH];
   logic             imem_we;

   logic [1:0]       state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instrword_q, instrword_d;
   logic             newinstr_q, newinstr_d;
   logic             pc_fault_q, pc_fault_d;
   logic [15:0]      instr_count_q, instr_count_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0]      fetch_word;
   logic [31:0]      pc4;
   logic [31:0]      br_off;
   logic [31:0]      npc;
   logic             npc_fault;
   logic             idle_like;

   assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_HALT);
   // Memory writes are only accepted while the sequencer is parked.
   assign imem_we    = load_en && idle_like && !reset;
   assign fetch_word = imem_q[pc_q[ADDR_W+1:2]];

   // Instruction memory write port; contents survive reset.
   always_ff @(posedge clock) begin
      if (imem_we) begin
         imem_q[load_addr] <= load_data;
      end
   end

   // Next-PC resolution for the instruction currently in its execute window.
   always_comb begin
      pc4    = pc_q + 32'd4;
      br_off = {{14{instrword_q[15]}}, instrword_q[15:0], 2'b00};
      unique case (instrword_q[31:26])
         OP_J:    npc = {pc4[31:28], instrword_q[25:0], 2'b00};
         OP_BEQ:  npc = br_equal ? (pc4 + br_off) : pc4;
         default: npc = pc4;
      endcase
      npc_fault = (npc[31:2] >= DEPTH_WORDS);
   end

   // Sequencer next-state logic.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instrword_d   = instrword_q;
      newinstr_d    = 1'b0;
      pc_fault_d    = pc_fault_q;
      instr_count_d = instr_count_q;
      cnt_d         = cnt_q;

      unique case (state_q)
         ST_IDLE, ST_HALT: begin
            // A simultaneous load wins over start.
            if (start && !load_en) begin
               state_d       = ST_ISSUE;
               pc_d          = RESET_PC;
               instr_count_d = 16'd0;
               pc_fault_d    = 1'b0;
            end
         end
         ST_ISSUE: begin
            if (fetch_word == HALT_WORD) begin
               state_d = ST_HALT;
            end else begin
               state_d       = ST_EXEC;
               instrword_d   = fetch_word;
               newinstr_d    = 1'b1;
               instr_count_d = instr_count_q + 16'd1;
               cnt_d         = '0;
            end
         end
         ST_EXEC: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (npc_fault) begin
                  state_d    = ST_HALT;
                  pc_fault_d = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
                  pc_d    = npc;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         instrword_q   <= 32'd0;
         newinstr_q    <= 1'b0;
         pc_fault_q    <= 1'b0;
         instr_count_q <= 16'd0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instrword_q   <= instrword_d;
         newinstr_q    <= newinstr_d;
         pc_fault_q    <= pc_fault_d;
         instr_count_q <= instr_count_d;
         cnt_q         <= cnt_d;
      end
   end

   assign instrword   = instrword_q;
   assign newinstr    = newinstr_q;
   assign pc          = pc_q;
   assign busy        = (state_q == ST_ISSUE) || (state_q == ST_EXEC);
   assign halted      = (state_q == ST_HALT);
   assign pc_fault    = pc_fault_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: sequencing, j/beq, fault halt, reset abort.
module tb_instr_fetch_seq;

   localparam logic [31:0] HALT_W = 32'hFFFFFFFF;

   logic        clock;
   logic        reset;
   logic        start;
   logic        load_en;
   logic [5:0]  load_addr;
   logic [31:0] load_data;
   logic        br_equal;
   logic [31:0] instrword;
   logic        newinstr;
   logic [31:0] pc;
   logic        busy;
   logic        halted;
   logic        pc_fault;
   logic [15:0] instr_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   instr_fetch_seq dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .br_equal    (br_equal),
      .instrword   (instrword),
      .newinstr    (newinstr),
      .pc          (pc),
      .busy        (busy),
      .halted      (halted),
      .pc_fault    (pc_fault),
      .instr_count (instr_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [5:0] a, input logic [31:0] d);
      @(negedge clock);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge clock);
      load_en   = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Returns number of negedges until newinstr seen (bounded).
   task automatic wait_new(input string tag, output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!newinstr && n < 100);
      check_eq({tag, "_seen"}, {31'd0, newinstr}, 32'd1);
   endtask

   task automatic wait_halt(input string tag);
      int n = 0;
      while (!halted && n < 100) begin
         @(negedge clock);
         n++;
      end
      check_eq({tag, "_halted"}, {31'd0, halted}, 32'd1);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      br_equal = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("rst_pc", pc, 32'd0);
      check_eq("rst_instr", instrword, 32'd0);
      check_eq("rst_flags", {28'd0, newinstr, busy, halted, pc_fault}, 32'd0);
      check_eq("rst_count", {16'd0, instr_count}, 32'd0);
      reset = 1'b0;

      // Straight-line program ending in HALT_WORD.
      load_word(6'd0, 32'h00000020);
      load_word(6'd1, 32'h00221820);
      load_word(6'd2, 32'h00431020);
      load_word(6'd3, HALT_W);
      check_eq("idle_busy", {31'd0, busy}, 32'd0);
      pulse_start();
      check_eq("issue_busy", {31'd0, busy}, 32'd1);
      wait_new("t1_i0", cyc);
      check_eq("t1_lat", cyc, 32'd1);
      check_eq("t1_pc0", pc, 32'd0);
      check_eq("t1_w0", instrword, 32'h00000020);
      check_eq("t1_cnt1", {16'd0, instr_count}, 32'd1);
      @(negedge clock);
      check_eq("t1_pulse_len", {31'd0, newinstr}, 32'd0);
      check_eq("t1_hold", instrword, 32'h00000020);
      wait_new("t1_i1", cyc);
      check_eq("t1_space1", cyc, 32'd3);
      check_eq("t1_pc1", pc, 32'd4);
      check_eq("t1_w1", instrword, 32'h00221820);
      wait_new("t1_i2", cyc);
      check_eq("t1_space2", cyc, 32'd4);
      check_eq("t1_pc2", pc, 32'd8);
      wait_halt("t1");
      check_eq("t1_hpc", pc, 32'd12);
      check_eq("t1_hcnt", {16'd0, instr_count}, 32'd3);
      check_eq("t1_hfault", {31'd0, pc_fault}, 32'd0);
      check_eq("t1_hword", instrword, 32'h00431020);

      // Jump to word 5.
      load_word(6'd0, 32'h08000005);
      load_word(6'd5, 32'h00A00020);
      load_word(6'd6, HALT_W);
      pulse_start();
      wait_new("t2_j", cyc);
      check_eq("t2_jpc", pc, 32'd0);
      wait_new("t2_tgt", cyc);
      check_eq("t2_tpc", pc, 32'd20);
      check_eq("t2_tword", instrword, 32'h00A00020);
      wait_halt("t2");
      check_eq("t2_hpc", pc, 32'd24);
      check_eq("t2_hcnt", {16'd0, instr_count}, 32'd2);

      // beq at pc=8, imm=-2: taken -> 4, not taken -> 12.
      load_word(6'd0, 32'h08000002);
      load_word(6'd1, 32'h00001020);
      load_word(6'd2, 32'h1000FFFE);
      load_word(6'd3, HALT_W);
      br_equal = 1'b1;
      pulse_start();
      wait_new("t3_j", cyc);
      wait_new("t3_beq1", cyc);
      check_eq("t3_beq1_pc", pc, 32'd8);
      wait_new("t3_tak", cyc);
      check_eq("t3_taken_pc", pc, 32'd4);
      check_eq("t3_taken_w", instrword, 32'h00001020);
      br_equal = 1'b0;
      wait_new("t3_beq2", cyc);
      check_eq("t3_beq2_pc", pc, 32'd8);
      wait_halt("t3");
      check_eq("t3_nt_pc", pc, 32'd12);
      check_eq("t3_cnt", {16'd0, instr_count}, 32'd4);

      // Jump to word 64 is out of range.
      load_word(6'd0, 32'h08000040);
      pulse_start();
      wait_new("t4_j", cyc);
      wait_halt("t4");
      check_eq("t4_fault", {31'd0, pc_fault}, 32'd1);
      check_eq("t4_pc", pc, 32'd0);
      check_eq("t4_cnt", {16'd0, instr_count}, 32'd1);

      // Restart clears fault; load/start during EXEC are ignored.
      load_word(6'd0, 32'h00000020);
      load_word(6'd1, 32'h00002020);
      load_word(6'd2, HALT_W);
      pulse_start();
      check_eq("t5_fault_clr", {31'd0, pc_fault}, 32'd0);
      check_eq("t5_halt_clr", {31'd0, halted}, 32'd0);
      wait_new("t5_i0", cyc);
      check_eq("t5_pc0", pc, 32'd0);
      load_en = 1'b1; load_addr = 6'd1; load_data = 32'hDEAD0000; start = 1'b1;
      @(negedge clock);
      load_en = 1'b0; start = 1'b0;
      wait_new("t5_i1", cyc);
      check_eq("t5_pc1", pc, 32'd4);
      check_eq("t5_w1", instrword, 32'h00002020);
      wait_halt("t5");
      check_eq("t5_hpc", pc, 32'd8);
      check_eq("t5_cnt", {16'd0, instr_count}, 32'd2);

      // Reset on the second EXEC cycle abandons the instruction.
      pulse_start();
      wait_new("t6_i0", cyc);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_eq("t6_pc", pc, 32'd0);
      check_eq("t6_instr", instrword, 32'd0);
      check_eq("t6_flags", {28'd0, newinstr, busy, halted, pc_fault}, 32'd0);
      check_eq("t6_cnt", {16'd0, instr_count}, 32'd0);
      @(negedge clock);
      check_eq("t6_no_repulse", {30'd0, newinstr, busy}, 32'd0);
      pulse_start();
      wait_new("t6_r0", cyc);
      check_eq("t6_r0_w", instrword, 32'h00000020);
      wait_new("t6_r1", cyc);
      check_eq("t6_r1_w", instrword, 32'h00002020);
      wait_halt("t6");
      check_eq("t6_hcnt", {16'd0, instr_count}, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
Instruction-fetch sequencer feeding the single-cycle-datapath CPU core. It holds the PC and a loadable instruction memory, and resolves j/beq branches. It presents one instruction word at a time on instrword, marks each new instruction with a one-cycle newinstr pulse, and holds the word for a fixed execute window before advancing.

Parameters:
IMEM_DEPTH, 64, instruction memory depth in 32-bit words
ADDR_W, 6, word-address width, clog2(IMEM_DEPTH)
CYCLES_PER_INSTR, 3, execute-window length in clocks after the issue cycle (>=1)
HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops the sequencer
RESET_PC, 32'h00000000, byte address of the first instruction

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin or restart execution from RESET_PC (honoured in IDLE/HALT only)
load_en  in  1  instruction-memory write strobe (honoured in IDLE/HALT only)
load_addr  in  ADDR_W  word address for load
load_data  in  32  word to store
br_equal  in  1  rs==rt compare from the datapath, sampled on the last EXEC cycle
instrword  out  32  current instruction to the CPU core
newinstr  out  1  one-cycle pulse marking a new instrword
pc  out  32  byte address of the current instruction
busy  out  1  high in ISSUE/EXEC
halted  out  1  high in HALT
pc_fault  out  1  sticky: halted because the next PC fell outside memory
instr_count  out  16  instructions issued since the last start (wraps at 2^16)

Behaviour:
- Reset, synchronous with priority over everything. Values after reset: state=IDLE, pc=RESET_PC, instrword=0, newinstr=0, busy=0, halted=0, pc_fault=0, instr_count=0, exec counter=0.
- Reset does not clear instruction memory contents.
- States: IDLE, ISSUE, EXEC, HALT.
- IDLE:
  - load_en writes imem[load_addr]=load_data.
  - start=1 -> ISSUE, pc=RESET_PC, instr_count=0.
  - start and load_en in the same cycle: the load is performed and the start is ignored.
- ISSUE (1 cycle). Fetch w=imem[pc>>2]:
  - If w==HALT_WORD -> HALT. instrword unchanged, no newinstr pulse, instr_count unchanged.
  - Otherwise the register update makes instrword=w, newinstr=1, instr_count+1 on the following edge; next state EXEC with counter=0.
  - newinstr is therefore high for exactly the first EXEC cycle.
- EXEC:
  - newinstr=0 after its first cycle; instrword and pc held stable.
  - Counter increments each cycle.
  - On the cycle where counter==CYCLES_PER_INSTR-1, compute npc from instrword, with pc4 = pc+4:
    - opcode 6'd2 (j): npc = {pc4[31:28], instrword[25:0], 2'b00}.
    - opcode 6'd4 (beq): npc = br_equal ? pc4 + (sext(instrword[15:0])<<2) : pc4.
    - All other opcodes: npc = pc4.
    - 32-bit wrap-around arithmetic.
  - If npc[31:2] >= IMEM_DEPTH -> HALT with pc_fault=1 and pc unchanged. Otherwise pc=npc and go to ISSUE.
- Issue cadence: one instruction every CYCLES_PER_INSTR+1 clocks. EXEC length is exactly CYCLES_PER_INSTR cycles.
- HALT:
  - halted=1, busy=0; instrword holds the last issued word.
  - load_en is honoured.
  - start -> ISSUE with pc=RESET_PC, instr_count=0, pc_fault=0, halted=0.
- start and load_en are ignored in ISSUE/EXEC; memory is not modified.
- br_equal is don't-care except on the last EXEC cycle of a beq.
- pc[1:0] is always 0 by construction; npc low bits are forced 0 for j and beq.
- Reset asserted mid-EXEC: the next cycle is IDLE with all outputs at reset values; the in-flight instruction is abandoned and newinstr is not re-pulsed.

Test Plan:
- Load imem[0..2] with three R-type words and imem[3]=HALT_WORD, pulse start -> newinstr pulses at 4-clock spacing, pc=0,4,8, then halted=1, instr_count=3, pc=12, pc_fault=0.
- imem[0]=j with target field 5 (32'h08000005) -> after issue/EXEC, pc=20 and instrword=imem[5].
- beq at pc=8 with imm=-2 and br_equal=1 on the last EXEC cycle -> pc=4. Same word with br_equal=0 -> pc=12.
- j to word index 64 (IMEM_DEPTH=64) -> HALT with pc_fault=1 and pc unchanged. Then start -> pc_fault=0, execution restarts at pc=0.
- load_en pulse with load_addr=1, load_data=32'hDEAD0000 during EXEC -> imem[1] unchanged when later issued.
- Assert reset on the second EXEC cycle -> next cycle IDLE, pc=0, instrword=0, newinstr=0, busy=0, instr_count=0. Imem retained: start re-runs the same program.
